// File: rtl/frame_fill_ctrl.sv
// Per-frame raster sequencer: feeds coordinates to the metaball pipeline, maps returned
// field values to pixel colours and hands the finished back buffer over via swap handshake.
// Define FRAME_FILL_GRADIENT_EN for shaded (field MSB slice) colours instead of binary lit/unlit.
module frame_fill_ctrl #(
    parameter int unsigned        WIDTH   = 32,
    parameter int unsigned        HEIGHT  = 16,
    parameter int unsigned        FIELD_W = 16,
    parameter int unsigned        PIXEL_W = 8,
    parameter logic [FIELD_W-1:0] THRESH  = 16'h4000,
    parameter int unsigned        MAX_OUT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    output logic                              busy,
    output logic [$clog2(WIDTH)-1:0]          px_x,
    output logic [$clog2(HEIGHT)-1:0]         px_y,
    output logic                              px_valid,
    input  logic                              px_ready,
    input  logic                              field_valid,
    input  logic [FIELD_W-1:0]                field_in,
    output logic                              wr_en,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr,
    output logic [PIXEL_W-1:0]                wr_data,
    output logic                              swap_req,
    input  logic                              swap_ack,
    output logic                              err
);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned AW = $clog2(WIDTH*HEIGHT);
    localparam int unsigned OW = $clog2(MAX_OUT+1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH-1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT-1);
    localparam logic [AW-1:0] A_LAST = AW'(WIDTH*HEIGHT-1);
    localparam logic [OW-1:0] O_MAX  = OW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, SWAP} state_t;

    state_t             state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [OW-1:0]      outst_q, outst_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [PIXEL_W-1:0] wr_data_q, wr_data_d;
    logic               err_q, err_d;
    logic               holdoff_q, holdoff_d;
    logic               xfer, ret;
    logic [PIXEL_W-1:0] colour;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            outst_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            outst_q   <= outst_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            holdoff_q <= holdoff_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        outst_d   = outst_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        holdoff_d = 1'b0;

`ifdef FRAME_FILL_GRADIENT_EN
        colour = (field_in >= THRESH) ? field_in[FIELD_W-1 -: PIXEL_W] : '0;
`else
        colour = (field_in >= THRESH) ? '1 : '0;
`endif

        px_valid = (state_q == SCAN) && (outst_q != O_MAX);
        xfer     = px_valid && px_ready;
        // A result with nothing outstanding is stray (e.g. in flight across a reset).
        ret      = field_valid && (outst_q != '0);

        if (xfer) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        if (xfer && !ret)      outst_d = outst_q + 1'b1;
        else if (!xfer && ret) outst_d = outst_q - 1'b1;

        if (field_valid && !ret) err_d = 1'b1;

        wr_en_d = ret;
        if (ret)     wr_data_d = colour;
        if (wr_en_q) wr_addr_d = (wr_addr_q == A_LAST) ? '0 : wr_addr_q + 1'b1;

        case (state_q)
            IDLE: begin
                // holdoff blocks a restart on the very cycle busy falls
                if (frame_start && !holdoff_q) begin
                    state_d   = SCAN;
                    x_d       = '0;
                    y_d       = '0;
                    wr_addr_d = '0;
                end
            end
            SCAN:    if (xfer && x_q == X_LAST && y_q == Y_LAST) state_d = DRAIN;
            DRAIN:   if (wr_en_q && wr_addr_q == A_LAST) state_d = SWAP;
            SWAP: begin
                if (swap_ack) begin
                    state_d   = IDLE;
                    holdoff_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy     = (state_q != IDLE);
        swap_req = (state_q == SWAP);
        px_x     = x_q;
        px_y     = y_q;
        wr_en    = wr_en_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
        err      = err_q;
    end
endmodule
